// File: rtl/efpga_bitbang_tx_if.sv
// Word stream into the BitBang serializer: host pushes 32-bit config words
// with valid/ready.
interface efpga_bitbang_tx_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input  word_ready);
  modport slave  (input  word_data, input  word_valid, output word_ready);
endinterface

// File: rtl/efpga_bitbang_tx.sv
// Serializes 32-bit configuration words onto the eFPGA BitBang port: data on
// s_clk rising edges, control (idle/commit pattern) on falling edges.
module efpga_bitbang_tx #(
  parameter int unsigned CLKS_PER_PHASE = 4,
  parameter logic [15:0] CTRL_IDLE      = 16'hFAB0,
  parameter logic [15:0] CTRL_COMMIT    = 16'hFAB1
) (
  input  logic               CLK,
  input  logic               resetn,
  efpga_bitbang_tx_if.slave  word,
  output logic               busy,
  output logic               s_clk,
  output logic               s_data,
  output logic [15:0]        words_sent
);

  typedef enum logic [2:0] {IDLE, D_SETUP, CLK_HI, C_SETUP, CLK_LO} state_t;

  localparam logic [7:0] PH_LAST = 8'(CLKS_PER_PHASE - 1);

  state_t      r_state;
  logic [31:0] r_data;
  logic [31:0] r_ctrl;
  logic [4:0]  r_idx;
  logic [7:0]  r_phase;
  logic        r_ready;
  logic        r_busy;
  logic        r_sclk;
  logic        r_sdata;
  logic [15:0] r_words;
  logic        w_last;

  assign w_last          = (r_phase == PH_LAST);
  assign word.word_ready = r_ready;
  assign busy            = r_busy;
  assign s_clk           = r_sclk;
  assign s_data          = r_sdata;
  assign words_sent      = r_words;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_words <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ready is registered, so it first rises one cycle after reset release
          r_ready <= 1'b1;
          if (word.word_valid && r_ready) begin
            r_data  <= word.word_data;
            r_ctrl  <= {CTRL_IDLE, CTRL_COMMIT};
            r_idx   <= 5'd31;
            r_phase <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_sdata <= word.word_data[31];
            r_state <= D_SETUP;
          end
        end
        default: begin
          if (!w_last) begin
            r_phase <= r_phase + 8'd1;
          end else begin
            r_phase <= '0;
            // outputs for the next phase are set on the transition edge
            case (r_state)
              D_SETUP: begin
                r_sclk  <= 1'b1;
                r_state <= CLK_HI;
              end
              CLK_HI: begin
                r_sdata <= r_ctrl[31];
                r_state <= C_SETUP;
              end
              C_SETUP: begin
                r_sclk  <= 1'b0;
                r_state <= CLK_LO;
              end
              CLK_LO: begin
                if (r_idx != 5'd0) begin
                  r_idx   <= r_idx - 5'd1;
                  r_data  <= {r_data[30:0], 1'b0};
                  r_ctrl  <= {r_ctrl[30:0], 1'b0};
                  r_sdata <= r_data[30];
                  r_state <= D_SETUP;
                end else begin
                  r_words <= r_words + 16'd1;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_sdata <= 1'b0;
                  r_state <= IDLE;
                end
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
